// File: rtl/conf_int_mac_pkg.sv
// Shared definitions for the configurable-precision integer MAC pipeline:
// precision-mode encodings and the operand split width check.
package conf_int_mac_pkg;

    typedef enum logic [1:0] {
        PREC_FULL    = 2'd0,   // all four partial products
        PREC_NO_LL   = 2'd1,   // low x low product dropped
        PREC_HH_ONLY = 2'd2,   // only the high x high product kept
        PREC_RSVD    = 2'd3    // reserved, treated as full precision
    } prec_e;

    localparam int PN_MIN = 32'sd1;

    // The low part must be at least one bit and both low parts together
    // must leave at least one high bit in the operand.
    function automatic bit split_widths_ok(input int op_bits, input int pn);
        return (pn >= PN_MIN) && ((pn + pn) < op_bits);
    endfunction

endpackage

// File: rtl/conf_int_mac_pipe_if.sv
// Handshake and data bundle of the MAC pipeline: input transaction side
// (valid/ready, operands, mode) and result side (valid/ready, d).
interface conf_int_mac_pipe_if #(
    parameter int OP_BITWIDTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [OP_BITWIDTH-1:0] a;
    logic [OP_BITWIDTH-1:0] b;
    logic [OP_BITWIDTH-1:0] c;
    logic [1:0]             prec;
    logic                   acc_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [OP_BITWIDTH-1:0] d;

    modport master (
        output in_valid, a, b, c, prec, acc_mode, out_ready,
        input  in_ready, out_valid, d
    );

    modport slave (
        input  in_valid, a, b, c, prec, acc_mode, out_ready,
        output in_ready, out_valid, d
    );
endinterface

// File: rtl/conf_int_mac_pp.sv
// Combinational operand split and the four partial products, masked by the
// precision mode. Products are kept OP_BITWIDTH wide: every bit above that
// would be shifted out of the truncated sum anyway.
module conf_int_mac_pp
    import conf_int_mac_pkg::*;
#(
    parameter int OP_BITWIDTH = 32,
    parameter int Pn          = 4
) (
    input  logic [OP_BITWIDTH-1:0] a,
    input  logic [OP_BITWIDTH-1:0] b,
    input  prec_e                  prec,
    output logic [OP_BITWIDTH-1:0] ll,
    output logic [OP_BITWIDTH-1:0] hl,
    output logic [OP_BITWIDTH-1:0] lh,
    output logic [OP_BITWIDTH-1:0] hh
);
    logic [OP_BITWIDTH-1:0] a_lo_s, a_hi_s, b_lo_s, b_hi_s;
    logic [OP_BITWIDTH-1:0] ll_raw_s, hl_raw_s, lh_raw_s, hh_raw_s;

    assign a_lo_s = {{(OP_BITWIDTH-Pn){1'b0}}, a[Pn-1:0]};
    assign a_hi_s = {{Pn{1'b0}}, a[OP_BITWIDTH-1:Pn]};
    assign b_lo_s = {{(OP_BITWIDTH-Pn){1'b0}}, b[Pn-1:0]};
    assign b_hi_s = {{Pn{1'b0}}, b[OP_BITWIDTH-1:Pn]};

    assign ll_raw_s = a_lo_s * b_lo_s;
    assign hl_raw_s = a_hi_s * b_lo_s;
    assign lh_raw_s = a_lo_s * b_hi_s;
    assign hh_raw_s = a_hi_s * b_hi_s;

    // Drop the partial products the selected precision mode excludes.
    always_comb begin
        ll = ll_raw_s;
        hl = hl_raw_s;
        lh = lh_raw_s;
        hh = hh_raw_s;
        case (prec)
            PREC_FULL, PREC_RSVD: begin
                ll = ll_raw_s;
            end
            PREC_NO_LL: begin
                ll = {OP_BITWIDTH{1'b0}};
            end
            PREC_HH_ONLY: begin
                ll = {OP_BITWIDTH{1'b0}};
                hl = {OP_BITWIDTH{1'b0}};
                lh = {OP_BITWIDTH{1'b0}};
            end
            default: begin
                ll = ll_raw_s;
            end
        endcase
    end
endmodule

// File: rtl/conf_int_mac_pipe.sv
// Two-stage pipelined configurable-precision integer MAC.
// Stage 1 registers the masked partial products, stage 2 sums them with the
// addend (c, or the previous result d in accumulate mode) into d.
// Build option: define CONF_INT_MAC_SAT_EN for an unsigned-saturating final
// add; otherwise the add wraps modulo 2^OP_BITWIDTH.
module conf_int_mac_pipe
    import conf_int_mac_pkg::*;
#(
    parameter int OP_BITWIDTH = 32,
    parameter int Pn          = 4
) (
    input  logic                clk,
    input  logic                rst,
    conf_int_mac_pipe_if.slave  bus
);
    if (!split_widths_ok(OP_BITWIDTH, Pn)) begin : g_bad_split
        $error("conf_int_mac_pipe: illegal Pn for OP_BITWIDTH");
    end

    logic [OP_BITWIDTH-1:0] ll_s, hl_s, lh_s, hh_s;
    logic [OP_BITWIDTH-1:0] ll_r, hl_r, lh_r, hh_r, c_r;
    logic                   acc_r;
    logic                   s1_valid_r;
    logic [OP_BITWIDTH-1:0] d_r;
    logic                   out_valid_r;

    logic                   s2_adv_s;
    logic                   in_ready_s;
    logic                   accept_s;
    logic [OP_BITWIDTH-1:0] mul_s;
    logic [OP_BITWIDTH-1:0] addend_s;
    logic [OP_BITWIDTH-1:0] result_s;

    conf_int_mac_pp #(
        .OP_BITWIDTH (OP_BITWIDTH),
        .Pn          (Pn)
    ) u_pp (
        .a    (bus.a),
        .b    (bus.b),
        .prec (prec_e'(bus.prec)),
        .ll   (ll_s),
        .hl   (hl_s),
        .lh   (lh_s),
        .hh   (hh_s)
    );

    // Stage 2 moves when it has data and the output register is free;
    // stage 1 accepts when empty or draining into stage 2.
    assign s2_adv_s   = s1_valid_r & (~out_valid_r | bus.out_ready);
    assign in_ready_s = ~s1_valid_r | s2_adv_s;
    assign accept_s   = bus.in_valid & in_ready_s;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.d         = d_r;

    // Stage 1: capture masked partial products, addend and mode on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            ll_r       <= {OP_BITWIDTH{1'b0}};
            hl_r       <= {OP_BITWIDTH{1'b0}};
            lh_r       <= {OP_BITWIDTH{1'b0}};
            hh_r       <= {OP_BITWIDTH{1'b0}};
            c_r        <= {OP_BITWIDTH{1'b0}};
            acc_r      <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            ll_r       <= ll_s;
            hl_r       <= hl_s;
            lh_r       <= lh_s;
            hh_r       <= hh_s;
            c_r        <= bus.c;
            acc_r      <= bus.acc_mode;
        end else if (s2_adv_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Recombine the partial products, truncated to the operand width.
    always_comb begin
        mul_s = (hh_r << (Pn + Pn)) + (hl_r << Pn) + (lh_r << Pn) + ll_r;
        if (acc_r) begin
            addend_s = d_r;
        end else begin
            addend_s = c_r;
        end
    end

`ifdef CONF_INT_MAC_SAT_EN
    logic [OP_BITWIDTH:0] sum_s;

    // Saturating add: a carry out clamps the result to all ones.
    always_comb begin
        sum_s = {1'b0, mul_s} + {1'b0, addend_s};
        if (sum_s[OP_BITWIDTH]) begin
            result_s = {OP_BITWIDTH{1'b1}};
        end else begin
            result_s = sum_s[OP_BITWIDTH-1:0];
        end
    end
`else
    // Wrapping add modulo 2^OP_BITWIDTH.
    always_comb begin
        result_s = mul_s + addend_s;
    end
`endif

    // Stage 2 / output register: d doubles as the accumulator and keeps its
    // value after being consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_r         <= {OP_BITWIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else if (s2_adv_s) begin
            d_r         <= result_s;
            out_valid_r <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end
endmodule

// File: tb/tb_conf_int_mac_pipe.sv
// Directed self-checking bench for conf_int_mac_pipe (OP_BITWIDTH=32, Pn=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_conf_int_mac_pipe;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    conf_int_mac_pipe_if #(.OP_BITWIDTH(32)) bus ();

    conf_int_mac_pipe #(
        .OP_BITWIDTH (32),
        .Pn          (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [1:0] prec, input logic acc);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.c        = c;
        bus.prec     = prec;
        bus.acc_mode = acc;
    endtask

    logic [31:0] prec_exp [4];
    logic [31:0] sat_exp;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        prec_exp[0] = 32'd708;
        prec_exp[1] = 32'd693;
        prec_exp[2] = 32'd517;
        prec_exp[3] = 32'd708;
`ifdef CONF_INT_MAC_SAT_EN
        sat_exp = 32'hFFFF_FFFF;
`else
        sat_exp = 32'h0000_0010;
`endif
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.c         = 32'd0;
        bus.prec      = 2'd0;
        bus.acc_mode  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_d", bus.d, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Precision modes, a=0x13 b=0x25 c=5
        for (int p = 0; p < 4; p++) begin
            drive(32'h13, 32'h25, 32'd5, p[1:0], 1'b0);
            step();
            bus.in_valid = 1'b0;
            chk($sformatf("prec%0d_lat_ov", p), {31'd0, bus.out_valid}, 32'd0);
            step();
            chk($sformatf("prec%0d_ov", p), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("prec%0d_d", p), bus.d, prec_exp[p]);
        end

        // Accumulate chain, back to back
        drive(32'd2, 32'd3, 32'd10, 2'd0, 1'b0);
        step();
        drive(32'd4, 32'd5, 32'd0, 2'd0, 1'b1);
        step();
        chk("acc1_ov", {31'd0, bus.out_valid}, 32'd1);
        chk("acc1_d", bus.d, 32'd16);
        drive(32'd1, 32'd1, 32'd0, 2'd0, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("acc2_d", bus.d, 32'd36);
        step();
        chk("acc3_ov", {31'd0, bus.out_valid}, 32'd1);
        chk("acc3_d", bus.d, 32'd37);

        // Wrap / saturation
        drive(32'hFFFF_FFFF, 32'd2, 32'd0, 2'd0, 1'b0);
        step();
        drive(32'hFFFF_FFF0, 32'd1, 32'd0, 2'd0, 1'b0);
        step();
        chk("wrap_mul_d", bus.d, 32'hFFFF_FFFE);
        drive(32'h20, 32'd1, 32'd0, 2'd0, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("seed_d", bus.d, 32'hFFFF_FFF0);
        step();
        chk("wrap_acc_d", bus.d, sat_exp);
        step();
        chk("drain_ov", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure: 3 transactions, out_ready low
        bus.out_ready = 1'b0;
        drive(32'd3, 32'd3, 32'd1, 2'd0, 1'b0);
        step();
        chk("bp_ready1", {31'd0, bus.in_ready}, 32'd1);
        drive(32'd5, 32'd6, 32'd0, 2'd0, 1'b0);
        step();
        drive(32'd7, 32'd2, 32'd4, 2'd0, 1'b0);
        chk("bp_ready_low", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_ov", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_d1", bus.d, 32'd10);
        step();
        step();
        chk("bp_hold_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_hold_ov", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_hold_d", bus.d, 32'd10);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("bp_d2", bus.d, 32'd30);
        chk("bp_ov2", {31'd0, bus.out_valid}, 32'd1);
        step();
        chk("bp_d3", bus.d, 32'd18);
        chk("bp_ov3", {31'd0, bus.out_valid}, 32'd1);
        step();
        chk("bp_empty_ov", {31'd0, bus.out_valid}, 32'd0);

        // Reset with both stages full
        bus.out_ready = 1'b0;
        drive(32'd2, 32'd2, 32'd0, 2'd0, 1'b0);
        step();
        drive(32'd3, 32'd3, 32'd0, 2'd0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("pre_rst_d", bus.d, 32'd4);
        chk("pre_rst_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_ov", {31'd0, bus.out_valid}, 32'd0);
        chk("async_rst_d", bus.d, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("no_stale_ov%0d", i), {31'd0, bus.out_valid}, 32'd0);
        end
        drive(32'd3, 32'd4, 32'd99, 2'd0, 1'b1);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("post_rst_acc_ov", {31'd0, bus.out_valid}, 32'd1);
        chk("post_rst_acc_d", bus.d, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
